// File: rtl/quad_decoder.sv
// Quadrature front end: synchronises and glitch-filters encoder phases A/B,
// then decodes Gray-code transitions into a step strobe, direction and error flag.
module quad_decoder #(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic       quad_a,
  input  logic       quad_b,
  input  logic       err_clr,
  output logic       step,
  output logic       up_down,
  output logic       err,
  output logic [1:0] ab_filt
);

  localparam int unsigned AB_W = 2;

  logic [AB_W-1:0]  meta_q;
  logic [AB_W-1:0]  sync_q;
  logic [AB_W-1:0]  prev_q;
  logic [AB_W-1:0]  filt_q;
  logic [AB_W-1:0]  filt_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] run_c;
  logic             accept_c;
  logic [AB_W-1:0]  delta_c;
  logic             primed_q;
  logic             primed_d;
  logic             step_q;
  logic             step_d;
  logic             ud_q;
  logic             ud_d;
  logic             err_q;
  logic             err_d;

  // Gray position 00,01,11,10 -> 0,1,2,3
  function automatic logic [AB_W-1:0] gray2bin(input logic [AB_W-1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Two-flop synchroniser plus a one-cycle history of the synchronised pair
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= {quad_a, quad_b};
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // run_c is the number of consecutive samples the current differing value has been seen
  always_comb begin
    run_c    = (sync_q == prev_q) ? cnt_q + CNT_W'(1) : CNT_W'(1);
    cnt_d    = '0;
    accept_c = 1'b0;
    filt_d   = filt_q;
    if (sync_q != filt_q) begin
      if (run_c == CNT_W'(FILT_LEN)) begin
        accept_c = 1'b1;
        filt_d   = sync_q;
      end else begin
        cnt_d = run_c;
      end
    end
  end

  assign delta_c = gray2bin(sync_q) - gray2bin(filt_q);

  // Decode the accepted transition; the first accept after reset only sets the baseline
  always_comb begin
    primed_d = primed_q;
    step_d   = 1'b0;
    ud_d     = ud_q;
    err_d    = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (accept_c) begin
      if (!primed_q) begin
        primed_d = 1'b1;
      end else if (en) begin
        case (delta_c)
          2'd1: begin
            step_d = 1'b1;
            ud_d   = 1'b1;
          end
          2'd3: begin
            step_d = 1'b1;
            ud_d   = 1'b0;
          end
          2'd2:    err_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      filt_q   <= '0;
      primed_q <= 1'b0;
      step_q   <= 1'b0;
      ud_q     <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      filt_q   <= filt_d;
      primed_q <= primed_d;
      step_q   <= step_d;
      ud_q     <= ud_d;
      err_q    <= err_d;
    end
  end

  assign step    = step_q;
  assign up_down = ud_q;
  assign err     = err_q;
  assign ab_filt = filt_q;

endmodule
